// File: rtl/avr_irqctl_if.sv
// Register bus and CPU interrupt handshake for the AVR-style interrupt controller.
interface avr_irqctl_if;
  logic [1:0] io_a;
  logic       io_re;
  logic       io_we;
  logic [7:0] io_di;
  logic [7:0] io_do;
  logic [7:0] irq_in;
  logic       cpu_irq;
  logic [2:0] cpu_vec;
  logic       cpu_ack;
  logic       cpu_reti;

  modport master (
    output io_a, io_re, io_we, io_di, irq_in, cpu_ack, cpu_reti,
    input  io_do, cpu_irq, cpu_vec
  );

  modport slave (
    input  io_a, io_re, io_we, io_di, irq_in, cpu_ack, cpu_reti,
    output io_do, cpu_irq, cpu_vec
  );
endinterface

// File: rtl/avr_irqctl.sv
// Eight-line prioritised interrupt controller with edge/level modes and nested in-service tracking.
// state  | meaning
// S_IDLE | no request presented; picks lowest eligible line
// S_REQ  | cpu_vec presented to the CPU, waiting for ack or withdrawal
module avr_irqctl (
  input  logic        clk,
  input  logic        rst,
  avr_irqctl_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t     state, state_n;
  logic [2:0] vec, vec_n;
  logic [7:0] pend, mask, edge_mode, inserv, irq_q;
  logic [7:0] rise, raw, allow, eligible;
  logic [7:0] inserv_lo, ack_hot, reti_clr, pend_clr;
  logic [2:0] elig_idx;
  logic       any_elig, take;
  logic       wr_pend, wr_mask, wr_edge;

  assign wr_pend = bus.io_we && (bus.io_a == 2'd0);
  assign wr_mask = bus.io_we && (bus.io_a == 2'd1);
  assign wr_edge = bus.io_we && (bus.io_a == 2'd2);

  assign rise      = bus.irq_in & ~irq_q;
  assign raw       = (edge_mode & pend) | (~edge_mode & bus.irq_in);
  assign inserv_lo = inserv & (~inserv + 8'd1);
  // Bits strictly below the lowest in-service bit; all ones when nothing is in service.
  assign allow     = inserv_lo - 8'd1;
  assign eligible  = raw & mask & allow;
  assign any_elig  = |eligible;

  always_comb begin
    elig_idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (eligible[i]) elig_idx = 3'(i);
  end

  always_comb begin
    state_n = state;
    vec_n   = vec;
    take    = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_elig) begin
          state_n = S_REQ;
          vec_n   = elig_idx;
        end
      end
      S_REQ: begin
        if (bus.cpu_ack) begin
          take    = 1'b1;
          state_n = S_IDLE;
        end else if (!eligible[vec]) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign ack_hot  = take ? (8'd1 << vec) : 8'd0;
  assign reti_clr = bus.cpu_reti ? inserv_lo : 8'd0;
  assign pend_clr = (wr_pend ? bus.io_di : 8'd0) | (ack_hot & edge_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      vec   <= 3'd0;
    end else begin
      state <= state_n;
      vec   <= vec_n;
    end
  end

  // New edges override same-cycle clears from software or acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 8'h00;
      mask      <= 8'h00;
      edge_mode <= 8'h00;
      inserv    <= 8'h00;
      irq_q     <= 8'h00;
    end else begin
      pend   <= (pend & ~pend_clr) | (rise & edge_mode);
      inserv <= (inserv & ~reti_clr) | ack_hot;
      irq_q  <= bus.irq_in;
      if (wr_mask) mask      <= bus.io_di;
      if (wr_edge) edge_mode <= bus.io_di;
    end
  end

  always_comb begin
    bus.io_do = 8'h00;
    if (bus.io_re) begin
      case (bus.io_a)
        2'd0:    bus.io_do = pend;
        2'd1:    bus.io_do = mask;
        2'd2:    bus.io_do = edge_mode;
        default: bus.io_do = inserv;
      endcase
    end
  end

  assign bus.cpu_irq = (state == S_REQ);
  assign bus.cpu_vec = vec;
endmodule

// File: tb/tb_avr_irqctl.sv
// Self-checking bench for avr_irqctl: directed scenarios plus random traffic against a reference model.
module tb_avr_irqctl;
  logic clk = 1'b0;
  logic rst;

  avr_irqctl_if ifc ();
  avr_irqctl dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] irq_v;
  logic [7:0] last_do;
  logic       last_irq;
  logic [2:0] last_vec;

  logic [7:0] m_pend, m_mask, m_edge, m_inserv, m_prev;
  bit         m_req;
  int         m_vec;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_edge = 8'h00; m_inserv = 8'h00; m_prev = 8'h00;
    m_req = 1'b0; m_vec = 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [1:0] a, input logic re);
    if (!re) return 8'h00;
    case (a)
      2'd0:    return m_pend;
      2'd1:    return m_mask;
      2'd2:    return m_edge;
      default: return m_inserv;
    endcase
  endfunction

  function automatic void model_clock(input logic [1:0] a, input logic we, input logic [7:0] di,
                                      input logic [7:0] irq, input logic ack, input logic reti);
    bit         elig [8];
    bit         r;
    bit         taken;
    int         first_isr;
    int         first_elig;
    logic [7:0] npend;
    logic [7:0] nisr;
    taken = 1'b0; first_isr = 8; first_elig = -1;
    npend = m_pend; nisr = m_inserv;
    for (int i = 7; i >= 0; i--) if (m_inserv[i]) first_isr = i;
    for (int i = 0; i < 8; i++) begin
      r = m_edge[i] ? m_pend[i] : irq[i];
      elig[i] = r && m_mask[i] && (i < first_isr);
      if (elig[i] && first_elig < 0) first_elig = i;
    end
    if (!m_req) begin
      if (first_elig >= 0) begin m_req = 1'b1; m_vec = first_elig; end
    end else if (ack) begin
      taken = 1'b1; m_req = 1'b0;
    end else if (!elig[m_vec]) begin
      m_req = 1'b0;
    end
    if (reti && first_isr < 8) nisr[first_isr] = 1'b0;
    if (taken) begin
      nisr[m_vec] = 1'b1;
      if (m_edge[m_vec]) npend[m_vec] = 1'b0;
    end
    if (we && a == 2'd0) npend = npend & ~di;
    for (int i = 0; i < 8; i++) if (m_edge[i] && irq[i] && !m_prev[i]) npend[i] = 1'b1;
    if (we && a == 2'd1) m_mask = di;
    if (we && a == 2'd2) m_edge = di;
    m_pend = npend; m_inserv = nisr; m_prev = irq;
  endfunction

  task automatic drive(input logic [1:0] a, input logic re, input logic we, input logic [7:0] di,
                       input logic ack, input logic reti);
    ifc.io_a = a; ifc.io_re = re; ifc.io_we = we; ifc.io_di = di;
    ifc.irq_in = irq_v; ifc.cpu_ack = ack; ifc.cpu_reti = reti;
  endtask

  task automatic step(input logic [1:0] a, input logic re, input logic we, input logic [7:0] di,
                      input logic ack, input logic reti);
    @(negedge clk);
    drive(a, re, we, di, ack, reti);
    #1;
    last_do = ifc.io_do; last_irq = ifc.cpu_irq; last_vec = ifc.cpu_vec;
    check("cpu_irq", {7'd0, last_irq}, {7'd0, m_req});
    check("cpu_vec", {5'd0, last_vec}, 8'(m_vec));
    check("io_do", last_do, model_read(a, re));
    @(posedge clk);
    model_clock(a, we, di, irq_v, ack, reti);
  endtask

  task automatic idle();                                   step(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic ack_cyc();                                step(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic reti_cyc();                               step(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1); endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d); step(a, 1'b0, 1'b1, d, 1'b0, 1'b0); endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    step(a, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check(tag, last_do, exp);
  endtask

  task automatic expect_req(input logic irq, input logic [2:0] vec, input string tag);
    check({tag, "_irq"}, {7'd0, last_irq}, {7'd0, irq});
    if (irq) check({tag, "_vec"}, {5'd0, last_vec}, {5'd0, vec});
  endtask

  task automatic do_reset();
    @(negedge clk);
    irq_v = 8'h00;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_v = 8'h00;
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    do_reset();

    rd(2'd0, 8'h00, "rst_pend");
    rd(2'd3, 8'h00, "rst_inserv");

    // single edge request, ack clears PEND and marks in-service
    wr(2'd1, 8'h04); wr(2'd2, 8'h04);
    irq_v = 8'h04; idle();
    irq_v = 8'h00; rd(2'd0, 8'h04, "t1_pend");
    expect_req(1'b0, 3'd0, "t1_lat");
    ack_cyc(); expect_req(1'b1, 3'd2, "t1_req");
    rd(2'd0, 8'h00, "t1_pend_clr"); expect_req(1'b0, 3'd0, "t1_after");
    rd(2'd3, 8'h04, "t1_inserv");

    // level priority, in-service blocks lower priority, reti reopens
    do_reset();
    wr(2'd1, 8'hFF);
    irq_v = 8'h30; idle();
    ack_cyc(); expect_req(1'b1, 3'd4, "t2_req");
    irq_v = 8'h20; idle(); expect_req(1'b0, 3'd0, "t2_blocked");
    rd(2'd3, 8'h10, "t2_inserv");
    reti_cyc(); idle();
    rd(2'd3, 8'h00, "t2_inserv_clr"); expect_req(1'b1, 3'd5, "t2_vec5");

    // nesting
    do_reset();
    wr(2'd1, 8'hFF);
    irq_v = 8'h08; idle();
    ack_cyc(); expect_req(1'b1, 3'd3, "t3_first");
    irq_v = 8'h00; rd(2'd3, 8'h08, "t3_isr");
    irq_v = 8'h02; idle();
    ack_cyc(); expect_req(1'b1, 3'd1, "t3_preempt");
    irq_v = 8'h00; rd(2'd3, 8'h0A, "t3_nest");
    reti_cyc(); rd(2'd3, 8'h08, "t3_reti");

    // presented vector is held; masking withdraws the request
    do_reset();
    wr(2'd1, 8'hFF);
    irq_v = 8'h40; idle();
    irq_v = 8'h41; idle(); expect_req(1'b1, 3'd6, "t4_req");
    wr(2'd1, 8'hBF); expect_req(1'b1, 3'd6, "t4_hold");
    idle(); expect_req(1'b1, 3'd6, "t4_mask_seen");
    idle(); expect_req(1'b0, 3'd0, "t4_withdrawn");
    rd(2'd3, 8'h00, "t4_isr"); expect_req(1'b1, 3'd0, "t4_next");

    // write-1-clear against a new edge, then plain clear
    do_reset();
    wr(2'd2, 8'h01);
    irq_v = 8'h01; idle();
    irq_v = 8'h00; rd(2'd0, 8'h01, "t5_pend");
    irq_v = 8'h01; wr(2'd0, 8'h01); rd(2'd0, 8'h01, "t5_setwins");
    wr(2'd0, 8'h01); rd(2'd0, 8'h00, "t5_w1c");

    // ack-clear against a new edge on the same bit
    irq_v = 8'h00; wr(2'd1, 8'h01);
    irq_v = 8'h01; idle();
    irq_v = 8'h00; idle();
    irq_v = 8'h01; ack_cyc(); expect_req(1'b1, 3'd0, "t5_ackedge");
    rd(2'd0, 8'h01, "t5_ack_setwins");

    // simultaneous reti and ack
    do_reset();
    wr(2'd1, 8'hFF);
    irq_v = 8'h10; idle();
    ack_cyc(); expect_req(1'b1, 3'd4, "t5_first");
    irq_v = 8'h04; idle();
    step(2'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1); expect_req(1'b1, 3'd2, "t5_both");
    irq_v = 8'h00; rd(2'd3, 8'h04, "t5_reti_ack");

    // asynchronous reset while a request is presented
    do_reset();
    wr(2'd1, 8'hFF); wr(2'd2, 8'hFF);
    irq_v = 8'h01; idle();
    irq_v = 8'h00; idle();
    idle(); expect_req(1'b1, 3'd0, "t6_pre");
    @(negedge clk);
    drive(2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_irq", {7'd0, ifc.cpu_irq}, 8'h00);
    check("t6_async_do", ifc.io_do, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd(2'd0, 8'h00, "t6_pend"); rd(2'd1, 8'h00, "t6_mask");
    rd(2'd2, 8'h00, "t6_edge"); rd(2'd3, 8'h00, "t6_inserv");

    // random traffic
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 3) == 0) irq_v = irq_v ^ (8'($urandom) & 8'($urandom));
        step(2'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 8'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
